// File: rtl/bm_dag2_pkg.sv
// Shared types and helpers for the two-bit DAG microbenchmark result path.
package bm_dag2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_CAPTURE,
    S_DRAIN
  } sink_state_t;

  localparam int DAG2_BITS = 2;

  // Rotate-left-by-one over the low `width` bits, then XOR in the new sample.
  function automatic logic [31:0] rotxor(input logic [31:0] sum, input logic [31:0] data,
                                         input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return ((((sum << 1) | (sum >> (width - 1))) & mask) ^ data) & mask;
  endfunction

endpackage

// File: rtl/bm_dag2_sink_fifo.sv
// Synchronous FIFO with a registered head (no fall-through: a push into an empty FIFO is visible next cycle).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bm_dag2_sink_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
      // Head register tracks the entry that will be at rd_ptr after this cycle.
      if (do_pop) begin
        if (count == (AW+1)'(1)) begin
          if (do_push) rdata <= wdata;
        end else begin
          rdata <= mem[rd_nxt];
        end
      end else if (do_push & empty) begin
        rdata <= wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bm_dag2_result_sink.sv
// Framed capture of {in1,in0} after a warm-up, buffered in a FIFO and drained over ready/valid.
// DAG2_SINK_CHECKSUM_EN adds a rotate-XOR checksum of accepted samples; otherwise checksum reads 0.
module bm_dag2_result_sink
  import bm_dag2_pkg::*;
#(
  parameter int BITS      = DAG2_BITS,
  parameter int DEPTH     = 8,
  parameter int WARMUP    = 3,
  parameter int FRAME_LEN = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [BITS-1:0] in0,
  input  logic            in1,
  output logic [BITS:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [BITS:0]   checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WARMUP + FRAME_LEN + 1) + 1;

  sink_state_t   state;
  logic [CW-1:0] cnt;
  logic [BITS:0] sample;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic          drain_empty;
  logic [AW:0]   count;

  assign sample      = {in1, in0};
  assign pop         = out_valid & out_ready;
  assign push        = (state == S_CAPTURE);
  assign push_ok     = ~full | pop;
  assign out_valid   = ~empty;
  // No pushes happen in DRAIN, so the FIFO is empty next cycle if it is now or its last entry leaves.
  assign drain_empty = empty | ((count == (AW+1)'(1)) & pop);

  bm_dag2_sink_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BITS + 1)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (sample),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= (WARMUP == 0) ? S_CAPTURE : S_WARMUP;
          end
        end
        S_WARMUP: begin
          if (cnt == CW'(WARMUP - 1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (!push_ok) overflow <= 1'b1;
          if (cnt == CW'(FRAME_LEN - 1)) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // done is raised for the single cycle spent empty in DRAIN, then we leave.
          if (done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (drain_empty) begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DAG2_SINK_CHECKSUM_EN
  logic [BITS:0] csum;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum <= '0;
    end else if ((state == S_IDLE) && start) begin
      csum <= '0;
    end else if (push && push_ok) begin
      csum <= (BITS+1)'(rotxor(32'(csum), 32'(sample), BITS + 1));
    end
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bm_dag2_result_sink.sv
// Directed bench for bm_dag2_result_sink: three instances cover the basic frame, overflow and zero-warm-up cases.
module tb_bm_dag2_result_sink;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] in0;
  logic in1;

  logic start_a, ready_a, valid_a, busy_a, done_a, ovf_a;
  logic [2:0] data_a, csum_a;
  logic start_b, ready_b, valid_b, busy_b, done_b, ovf_b;
  logic [2:0] data_b, csum_b;
  logic start_c, ready_c, valid_c, busy_c, done_c, ovf_c;
  logic [2:0] data_c, csum_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bm_dag2_result_sink #(.BITS(2), .DEPTH(8), .WARMUP(3), .FRAME_LEN(4)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .in0(in0), .in1(in1),
    .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .checksum(csum_a));

  bm_dag2_result_sink #(.BITS(2), .DEPTH(8), .WARMUP(3), .FRAME_LEN(10)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .in0(in0), .in1(in1),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .checksum(csum_b));

  bm_dag2_result_sink #(.BITS(2), .DEPTH(8), .WARMUP(0), .FRAME_LEN(1)) dut_c (
    .clock(clock), .reset(reset), .start(start_c), .in0(in0), .in1(in1),
    .out_data(data_c), .out_valid(valid_c), .out_ready(ready_c), .busy(busy_c),
    .done(done_c), .overflow(ovf_c), .checksum(csum_c));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v);
    logic [2:0] b;
    b   = 3'(v);
    in0 = b[1:0];
    in1 = b[2];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    drive(0);
    tick; tick;
    vectors++;
    if ({valid_a, busy_a, done_a, ovf_a, data_a, csum_a} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_a got %b want 0", {valid_a, busy_a, done_a, ovf_a, data_a, csum_a});
    end
    vectors++;
    if ({valid_b, busy_b, done_b, ovf_b, data_b, csum_b} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_b got %b want 0", {valid_b, busy_b, done_b, ovf_b, data_b, csum_b});
    end
    vectors++;
    if ({valid_c, busy_c, done_c, ovf_c, data_c, csum_c} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_c got %b want 0", {valid_c, busy_c, done_c, ovf_c, data_c, csum_c});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic_frame;
    int stim [11] = '{0, 7, 6, 5, 1, 2, 3, 4, 0, 0, 0};
    int ev   [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int ed   [11] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0};
    int edn  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int eb   [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [2:0] exp_csum;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(stim[k]);
      vectors++;
      if (valid_a !== 1'(ev[k])) begin
        miscompares++;
        $display("FAIL basic_valid@t+%0d got %b want %0d", k, valid_a, ev[k]);
      end
      if (ev[k] == 1) begin
        vectors++;
        if (data_a !== 3'(ed[k])) begin
          miscompares++;
          $display("FAIL basic_data@t+%0d got %0d want %0d", k, data_a, ed[k]);
        end
      end
      vectors++;
      if (done_a !== 1'(edn[k])) begin
        miscompares++;
        $display("FAIL basic_done@t+%0d got %b want %0d", k, done_a, edn[k]);
      end
      vectors++;
      if (busy_a !== 1'(eb[k])) begin
        miscompares++;
        $display("FAIL basic_busy@t+%0d got %b want %0d", k, busy_a, eb[k]);
      end
      tick;
    end
`ifdef DAG2_SINK_CHECKSUM_EN
    exp_csum = 3'd2;
`else
    exp_csum = 3'd0;
`endif
    vectors++;
    if (csum_a !== exp_csum || ovf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_csum_ovf got csum=%0d ovf=%b want csum=%0d ovf=0", csum_a, ovf_a, exp_csum);
    end
  endtask

  task automatic test_overflow;
    int pops = 0;
    bit seen = 0;
    ready_b = 1'b0;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      drive(k);
      tick;
    end
    drive(0);
    vectors++;
    if (ovf_b !== 1'b1 || valid_b !== 1'b1 || data_b !== 3'd4 || busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_state got ovf=%b valid=%b data=%0d busy=%b want 1 1 4 1",
               ovf_b, valid_b, data_b, busy_b);
    end
    ready_b = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (done_b) begin
        seen = 1;
        break;
      end
      if (valid_b) begin
        vectors++;
        if (data_b !== 3'((4 + pops) % 8)) begin
          miscompares++;
          $display("FAIL ovf_drain[%0d] got %0d want %0d", pops, data_b, (4 + pops) % 8);
        end
        pops++;
      end
      tick;
    end
    vectors++;
    if (!seen || pops != 8) begin
      miscompares++;
      $display("FAIL ovf_drain_count got pops=%0d done=%0d want pops=8 done=1", pops, seen);
    end
    ready_b = 1'b0;
    tick;
    vectors++;
    if (busy_b !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_busy_end got %b want 0", busy_b);
    end
  endtask

  task automatic test_full_pop;
    int pops = 0;
    bit seen = 0;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    vectors++;
    if (ovf_b !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_ovf_clear got %b want 0", ovf_b);
    end
    for (int k = 1; k <= 40; k++) begin
      ready_b = (k >= 12);
      drive((k <= 13) ? k : 0);
      if (done_b) begin
        seen = 1;
        break;
      end
      if (k == 13) begin
        vectors++;
        if (ovf_b !== 1'b0 || valid_b !== 1'b1) begin
          miscompares++;
          $display("FAIL fullpop_after_push got ovf=%b valid=%b want 0 1", ovf_b, valid_b);
        end
      end
      if (valid_b && ready_b) begin
        vectors++;
        if (data_b !== 3'((4 + pops) % 8)) begin
          miscompares++;
          $display("FAIL fullpop_data[%0d] got %0d want %0d", pops, data_b, (4 + pops) % 8);
        end
        pops++;
      end
      tick;
    end
    vectors++;
    if (!seen || pops != 10 || ovf_b !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_total got pops=%0d done=%0d ovf=%b want 10 1 0", pops, seen, ovf_b);
    end
    ready_b = 1'b0;
    tick;
  endtask

  task automatic test_start_ignored;
    int pops = 0;
    int dn = 0;
    int done_at = 0;
    ready_a = 1'b1;
    start_a = 1'b1;
    tick;
    for (int k = 1; k <= 20; k++) begin
      start_a = (k == 5);
      drive(k);
      if (done_a) begin
        dn++;
        if (dn == 1) done_at = k;
      end
      if (valid_a && ready_a) begin
        vectors++;
        if (data_a !== 3'(4 + pops)) begin
          miscompares++;
          $display("FAIL restart_data[%0d] got %0d want %0d", pops, data_a, 4 + pops);
        end
        pops++;
      end
      tick;
    end
    start_a = 1'b0;
    vectors++;
    if (pops != 4 || dn != 1 || done_at != 9) begin
      miscompares++;
      $display("FAIL restart_frame got pops=%0d dones=%0d done_at=%0d want 4 1 9", pops, dn, done_at);
    end
  endtask

  task automatic test_reset_mid_capture;
    int pops = 0;
    int dn = 0;
    ready_a = 1'b0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      drive(k);
      if (k < 7) tick;
    end
    vectors++;
    if (valid_a !== 1'b1 || data_a !== 3'd4 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre got valid=%b data=%0d busy=%b want 1 4 1", valid_a, data_a, busy_a);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++;
    if ({valid_a, busy_a, done_a, ovf_a, data_a, csum_a} !== 10'd0) begin
      miscompares++;
      $display("FAIL midrst_post got %b want 0", {valid_a, busy_a, done_a, ovf_a, data_a, csum_a});
    end
    ready_a = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      drive(k);
      if (done_a) dn++;
      if (valid_a && ready_a) begin
        vectors++;
        if (data_a !== 3'(4 + pops)) begin
          miscompares++;
          $display("FAIL midrst_data[%0d] got %0d want %0d", pops, data_a, 4 + pops);
        end
        pops++;
      end
      tick;
    end
    vectors++;
    if (pops != 4 || dn != 1) begin
      miscompares++;
      $display("FAIL midrst_frame got pops=%0d dones=%0d want 4 1", pops, dn);
    end
  endtask

  task automatic test_no_warmup;
    ready_c = 1'b1;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    drive(5);
    vectors++;
    if (busy_c !== 1'b1 || valid_c !== 1'b0) begin
      miscompares++;
      $display("FAIL nowarm_t1 got busy=%b valid=%b want 1 0", busy_c, valid_c);
    end
    tick;
    drive(0);
    vectors++;
    if (valid_c !== 1'b1 || data_c !== 3'd5 || done_c !== 1'b0) begin
      miscompares++;
      $display("FAIL nowarm_t2 got valid=%b data=%0d done=%b want 1 5 0", valid_c, data_c, done_c);
    end
    tick;
    vectors++;
    if (done_c !== 1'b1 || valid_c !== 1'b0 || busy_c !== 1'b1) begin
      miscompares++;
      $display("FAIL nowarm_t3 got done=%b valid=%b busy=%b want 1 0 1", done_c, valid_c, busy_c);
    end
    tick;
    vectors++;
    if (done_c !== 1'b0 || busy_c !== 1'b0) begin
      miscompares++;
      $display("FAIL nowarm_t4 got done=%b busy=%b want 0 0", done_c, busy_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_pop();
    test_start_ignored();
    test_reset_mid_capture();
    test_no_warmup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
